icrc_mask_stream: RTL
=====================

Name: icrc_mask_stream

Overview:
- Streaming successor to the fixed 424-bit ICRC mask definition in the RDMA network path.
- Sits between the RoCEv2 packet stream and the ICRC CRC32 engine. It overwrites the variant header fields with all-ones so the CRC sees the invariant header.
- Selects IPv4 or IPv6 masking per packet. Handles headers that span several beats at any parametrised bus width, with full-throughput AXI4S handshaking.

Parameters:
- DATA_BITS, 512, tdata width; must be a multiple of 64 and at least 64.
- HDR_OFFSET, 0, number of leading bytes before the IP header (e.g. 14 for Ethernet). These bytes pass unmasked.
- EN_STATS, 1, when set, implements the packet and short-packet counters; when 0, those outputs are tied to 0.

Ports:
- nclk in 1: clock.
- nresetn in 1: asynchronous active-low reset.
- s_axis_tdata in DATA_BITS: input data. Byte k is tdata[8k+7:8k], in network byte order.
- s_axis_tkeep in DATA_BITS/8: input byte enables.
- s_axis_tlast in 1: last beat of packet.
- s_axis_tuser in 2: mode, sampled on the first beat only. 00 = pass-through, 01 = IPv4, 10 = IPv6, 11 = pass-through.
- s_axis_tvalid in 1: input valid.
- s_axis_tready out 1: input ready.
- m_axis_tdata out DATA_BITS: masked output data.
- m_axis_tkeep out DATA_BITS/8: output byte enables.
- m_axis_tlast out 1: output last.
- m_axis_tvalid out 1: output valid.
- m_axis_tready in 1: output ready.
- short_pkt out 1: one-cycle pulse on a short masked packet.
- pkt_cnt out 32: count of masked packets.
- short_cnt out 16: count of short packets.

Behaviour:
- Clock and reset: one clock, nclk. Reset nresetn is asynchronous and active-low.
- Reset values: m_axis_tvalid=0, s_axis_tready=1 (once out of reset), short_pkt=0, pkt_cnt=0, short_cnt=0, beat counter=0, FSM=IDLE. Any packet in flight at reset is dropped. The first beat after reset is treated as a packet start.
- Handshake:
  - Registered output stage plus a one-entry skid buffer.
  - Latency is 1 cycle from an input handshake to m_axis_tvalid.
  - Sustains one beat per cycle when m_axis_tready=1.
  - s_axis_tready is registered; it deasserts only when the skid buffer is full.
  - m_axis outputs hold stable while tvalid=1 and tready=0.
  - tkeep and tlast pass through unchanged.
- FSM states:
  - IDLE: waiting for the first beat.
  - HDR: inside the mask window.
  - BODY: past the mask window.
  - IDLE->HDR on the first-beat handshake. If mode is pass-through, go straight to BODY.
  - HDR->BODY when the beat count reaches the last window beat.
  - Any state->IDLE on a handshake with tlast=1. This includes a single-beat packet.
- Mode latching: the mode is latched from tuser on the first beat and held for the whole packet. tuser on later beats is ignored.
- Byte offset: the absolute byte offset of byte k is beat*DATA_BITS/8 + k. The beat counter saturates at the last window beat and never wraps.
- Mask window: relative offset r = absolute offset - HDR_OFFSET. A masked byte is ORed with its mask value.
  - IPv4 (window 33 B): r1=FF (TOS), r8=FF (TTL), r10–11=FF (IP checksum), r26–27=FF (UDP checksum), r32=FF (BTH resv8a).
  - IPv6 (window 53 B): r0=0F (traffic class high nibble), r1=FF, r2–3=FF (traffic class low nibble and flow label), r7=FF (hop limit), r46–47=FF (UDP checksum), r52=FF (BTH resv8a).
  - Bytes with r<0 or r beyond the window are unmodified.
  - Masking applies regardless of tkeep.
- Short-packet check:
  - A masked-mode packet is short if its tlast beat's highest byte offset with tkeep=1 is below HDR_OFFSET+window-1.
  - On a short packet: the packet is still forwarded, with bytes present masked.
  - short_pkt pulses one cycle, aligned with the output beat carrying tlast.
  - short_cnt increments, saturating at FFFF.
- pkt_cnt: increments by 1 on each masked-mode tlast output handshake and wraps mod 2^32. Pass-through packets are not counted.
- Back-to-back packets: a tlast beat followed immediately by a new first beat is handled with no bubble.

Test Plan:
- DATA_BITS=512, HDR_OFFSET=0, IPv4, 1-beat packet of all 00 with tkeep all ones → out bytes 1,8,10,11,26,27,32 = FF, all others 00; pkt_cnt=1; no short_pkt.
- DATA_BITS=64, HDR_OFFSET=14, IPv6, 9-beat packet of all 00 → bytes 14,15,16,17,21,60,61,66 = FF, except byte 14 = 0F. Bytes 0–13 stay 00. Output equals input delayed by 1 cycle.
- Mode 00 packet of AA pattern → output identical to input; pkt_cnt unchanged.
- IPv6 with DATA_BITS=64, tlast on beat 3 (bytes 0–31) → bytes 0–3 and 7 masked; short_pkt pulses with the tlast beat; short_cnt=1.
- Random m_axis_tready (50%) across 100 back-to-back IPv4 packets → no loss, duplication or reordering; mask positions correct; pkt_cnt=100.
- nresetn asserted mid-packet (during beat 2 of a multi-beat IPv6 packet) → m_axis_tvalid=0 immediately. The next packet is masked from its own first beat.

Source files
------------

// File: rtl/icrc_mask_stream.sv
// icrc_mask_stream: overwrites the variant RoCEv2 header fields with all-ones
// so the downstream ICRC engine sees the invariant header. The mask is applied on
// the input side; the result feeds a registered output stage with a one-entry skid
// buffer, giving full-throughput AXI4-Stream with a registered s_axis_tready.
module icrc_mask_stream #(
  parameter int DATA_BITS  = 512,
  parameter int HDR_OFFSET = 0,
  parameter bit EN_STATS   = 1'b1
) (
  input  logic                   nclk,
  input  logic                   nresetn,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [1:0]             s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   short_pkt,
  output logic [31:0]            pkt_cnt,
  output logic [15:0]            short_cnt
);

  localparam int BYTES   = DATA_BITS / 8;
  localparam int V4_END  = HDR_OFFSET + 32;   // absolute offset of last IPv4 window byte
  localparam int V6_END  = HDR_OFFSET + 52;   // absolute offset of last IPv6 window byte
  localparam int V4_LAST = V4_END / BYTES;    // beat holding the last IPv4 window byte
  localparam int V6_LAST = V6_END / BYTES;
  localparam int BEAT_W  = $clog2(V6_LAST + 2);
  // Stored beat: {short flag, count flag, tlast, tkeep, masked tdata}
  localparam int BW      = DATA_BITS + BYTES + 3;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [1:0]          mode_q, mode_d;

  logic                in_hs, out_hs;
  logic [1:0]          cur_mode;
  logic [BEAT_W-1:0]   cur_beat, cur_last;
  logic                mode_masked, mask_en, is_short;
  int                  hi_off, win_end;
  logic [DATA_BITS-1:0] mask_vec;
  logic [BW-1:0]       in_beat, out_q, skid_q;
  logic                out_valid_q, skid_valid_q, s_ready_q;

  // Mask value for relative header offset r under the given mode.
  function automatic logic [7:0] mask_val(input int r, input logic [1:0] md);
    logic [7:0] v;
    v = 8'h00;
    if (md == 2'b01) begin
      case (r)
        1, 8, 10, 11, 26, 27, 32: v = 8'hFF;
        default:                  v = 8'h00;
      endcase
    end else if (md == 2'b10) begin
      case (r)
        0:                       v = 8'h0F;
        1, 2, 3, 7, 46, 47, 52:  v = 8'hFF;
        default:                 v = 8'h00;
      endcase
    end
    return v;
  endfunction

  assign in_hs  = s_axis_tvalid & s_axis_tready;
  assign out_hs = out_valid_q & m_axis_tready;

  // The first beat of a packet takes its mode and beat index straight from the bus.
  assign cur_mode    = (state_q == IDLE) ? s_axis_tuser : mode_q;
  assign cur_beat    = (state_q == IDLE) ? '0 : beat_q;
  assign mode_masked = (cur_mode == 2'b01) || (cur_mode == 2'b10);
  assign mask_en     = mode_masked && (state_q != BODY);
  assign cur_last    = (cur_mode == 2'b10) ? BEAT_W'(V6_LAST) : BEAT_W'(V4_LAST);

  // One mask byte per lane, from the absolute byte offset of that lane.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
    assign mask_vec[gi*8 +: 8] = mask_en ?
      mask_val(int'(cur_beat) * BYTES + gi - HDR_OFFSET, cur_mode) : 8'h00;
  end

  // Short check: highest kept byte of the tlast beat falls before the window end.
  always_comb begin
    hi_off  = -1;
    win_end = (cur_mode == 2'b10) ? V6_END : V4_END;
    for (int k = 0; k < BYTES; k++) begin
      if (s_axis_tkeep[k]) hi_off = int'(cur_beat) * BYTES + k;
    end
    is_short = mask_en && s_axis_tlast && (hi_off < win_end);
  end

  assign in_beat = {is_short, mode_masked & s_axis_tlast, s_axis_tlast,
                    s_axis_tkeep, s_axis_tdata | mask_vec};

  // Next-state logic for the window FSM, beat counter and latched mode.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    mode_d  = mode_q;
    if (in_hs) begin
      if (state_q == IDLE) mode_d = s_axis_tuser;
      beat_d = (cur_beat >= cur_last) ? cur_last : cur_beat + BEAT_W'(1);
      if (state_q != BODY) begin
        state_d = (!mode_masked || cur_beat >= cur_last) ? BODY : HDR;
      end
      if (s_axis_tlast) begin
        state_d = IDLE;
        beat_d  = '0;
      end
    end
  end

  // Window FSM state register.
  always_ff @(posedge nclk or negedge nresetn) begin
    if (!nresetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
    end
  end

  // Output register plus skid entry; ready drops only while the skid entry is full.
  always_ff @(posedge nclk or negedge nresetn) begin
    if (!nresetn) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      s_ready_q    <= 1'b1;
    end else if (out_hs || !out_valid_q) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_hs;
        if (in_hs) out_q <= in_beat;
      end
      s_ready_q <= 1'b1;
    end else if (in_hs) begin
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
      s_ready_q    <= 1'b0;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_q[DATA_BITS-1:0];
  assign m_axis_tkeep  = out_q[DATA_BITS +: BYTES];
  assign m_axis_tlast  = out_q[BW-3];
  assign short_pkt     = out_hs & out_q[BW-1];

  if (EN_STATS) begin : g_stats
    logic [31:0] pkt_cnt_q;
    logic [15:0] short_cnt_q;
    // Packet counter wraps; short counter saturates.
    always_ff @(posedge nclk or negedge nresetn) begin
      if (!nresetn) begin
        pkt_cnt_q   <= 32'd0;
        short_cnt_q <= 16'd0;
      end else begin
        if (out_hs && out_q[BW-2]) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        if (short_pkt && short_cnt_q != 16'hFFFF) short_cnt_q <= short_cnt_q + 16'd1;
      end
    end
    assign pkt_cnt   = pkt_cnt_q;
    assign short_cnt = short_cnt_q;
  end else begin : g_no_stats
    assign pkt_cnt   = 32'd0;
    assign short_cnt = 16'd0;
  end

endmodule
